// File: rtl/ram_pkg.sv
// Shared definitions for param_sp_ram: write-mode codes and the
// clear-sequencer state encoding.
package ram_pkg;

    // Synchronous-read behaviour on a write cycle
    localparam logic [1:0] MODE_RF = 2'b00;
    localparam logic [1:0] MODE_WF = 2'b01;
    localparam logic [1:0] MODE_NC = 2'b10;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: after reset, sweeps every address once so the top can
// write INIT_VAL there, then drops busy.
// Ports: clk, rst (sync, active-high) in; busy, clr_we, clr_addr out.
module ram_clear_seq #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    import ram_pkg::*;

    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    clr_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                busy   = 1'b1;
                // No sweep write on a reset edge: the pointer restarts at 0
                clr_we = ~rst;
                ptr_d  = ptr_q + AW'(1);
                if (ptr_q == LAST)
                    state_d = S_IDLE;
            end
            S_IDLE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign clr_addr = ptr_q;

endmodule

// File: rtl/param_sp_ram.sv
// Parametrised single-port RAM with async read (spo), sync read (dout) with
// selectable write mode, optional output register and a post-reset clear.
// Ports: clk, rst, we, a, d, mode in; spo, dout, dout_valid, busy out.
module param_sp_ram #(
    parameter int          DW       = 8,
    parameter int          AW       = 4,
    parameter int          OUT_REG  = 0,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    input  logic [1:0]    mode,
    output logic [DW-1:0] spo,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy
);
    import ram_pkg::*;

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] r1_q, r1_d;
    logic          v1_q;

    ram_clear_seq #(
        .AW(AW)
    ) u_clr (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // The sweep owns the write port while busy; user writes are dropped
    always_comb begin
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        if (busy) begin
            wr_en   = clr_we;
            wr_addr = clr_addr;
            wr_data = INIT_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign spo = mem[a];

    always_comb begin
        r1_d = r1_q;
        if (!busy) begin
            if (!we) begin
                r1_d = mem[a];
            end else begin
                unique case (mode)
                    MODE_WF: r1_d = d;
                    MODE_NC: r1_d = r1_q;
                    default: r1_d = mem[a];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            r1_q <= r1_d;
            v1_q <= ~busy;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DW-1:0] r2_q;
        logic          v2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r2_q <= '0;
                v2_q <= 1'b0;
            end else begin
                r2_q <= r1_q;
                v2_q <= v1_q;
            end
        end

        assign dout       = r2_q;
        assign dout_valid = v2_q;
    end else begin : g_noreg
        assign dout       = r1_q;
        assign dout_valid = v1_q;
    end

endmodule

// File: tb/tb_param_sp_ram.sv
// Self-checking bench for param_sp_ram: two instances (OUT_REG=0/INIT 00
// and OUT_REG=1/INIT AA) share stimulus and are checked against a model.
module tb_param_sp_ram;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic [3:0] a = '0;
    logic [7:0] d = '0;
    logic [1:0] mode = '0;

    logic [7:0] spo0, dout0, spo1, dout1;
    logic       dv0, dv1, busy0, busy1;

    always #5 clk = ~clk;

    param_sp_ram #(
        .DW(8), .AW(4), .OUT_REG(0), .INIT_VAL(8'h00)
    ) dut0 (
        .clk(clk), .rst(rst), .we(we), .a(a), .d(d), .mode(mode),
        .spo(spo0), .dout(dout0), .dout_valid(dv0), .busy(busy0)
    );

    param_sp_ram #(
        .DW(8), .AW(4), .OUT_REG(1), .INIT_VAL(8'hAA)
    ) dut1 (
        .clk(clk), .rst(rst), .we(we), .a(a), .d(d), .mode(mode),
        .spo(spo1), .dout(dout1), .dout_valid(dv1), .busy(busy1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model
    logic [7:0] m0 [DEPTH];
    logic [7:0] m1 [DEPTH];
    bit         known [DEPTH];
    int         busy_left = 0;
    bit         rst_seen = 0;
    logic [7:0] e_r1_0 = '0, e_r1_1 = '0, e_r2_1 = '0;
    bit         e_v1 = 0, e_v2 = 0;
    logic [7:0] spo0_pre, spo1_pre;

    typedef struct {
        logic       w;
        logic [3:0] ad;
        logic [7:0] dd;
        logic [1:0] md;
        logic [7:0] spo_exp;
        logic [7:0] dout_exp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic w, input logic [3:0] ad,
                        input logic [7:0] dd, input logic [1:0] md);
        logic [7:0] o0, o1;
        bit         bz;
        rst = r; we = w; a = ad; d = dd; mode = md;
        @(negedge clk);
        bz = (busy_left > 0);
        spo0_pre = spo0;
        spo1_pre = spo1;
        if (rst_seen) begin
            chk("busy0", {7'b0, busy0}, {7'b0, bz});
            chk("busy1", {7'b0, busy1}, {7'b0, bz});
        end
        if (known[ad]) begin
            chk("spo0", spo0, m0[ad]);
            chk("spo1", spo1, m1[ad]);
        end
        o0 = m0[ad];
        o1 = m1[ad];
        // output pipeline uses the pre-edge stage-1 values
        e_r2_1 = r ? 8'h00 : e_r1_1;
        e_v2   = r ? 1'b0 : e_v1;
        if (r) begin
            e_r1_0 = '0;
            e_r1_1 = '0;
            e_v1   = 0;
        end else begin
            e_v1 = !bz;
            if (!bz) begin
                if (!w || md == 2'b00 || md == 2'b11) begin
                    e_r1_0 = o0;
                    e_r1_1 = o1;
                end else if (md == 2'b01) begin
                    e_r1_0 = dd;
                    e_r1_1 = dd;
                end
            end
        end
        if (!bz && w) begin
            m0[ad] = dd;
            m1[ad] = dd;
            known[ad] = 1;
        end
        if (r) begin
            busy_left = DEPTH;
            rst_seen  = 1;
        end else if (bz) begin
            m0[DEPTH - busy_left] = 8'h00;
            m1[DEPTH - busy_left] = 8'hAA;
            known[DEPTH - busy_left] = 1;
            busy_left--;
        end
        @(posedge clk);
        #1;
        if (rst_seen) begin
            chk("dout0", dout0, e_r1_0);
            chk("dv0", {7'b0, dv0}, {7'b0, e_v1});
            chk("dout1", dout1, e_r2_1);
            chk("dv1", {7'b0, dv1}, {7'b0, e_v2});
        end
    endtask

    task automatic idle(input logic [3:0] ad);
        tick(1'b0, 1'b0, ad, 8'h00, 2'b00);
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, 4'd5,  8'h23, 2'b01, 8'h00, 8'h23};
        tbl[1] = '{1'b1, 4'd5,  8'h45, 2'b00, 8'h23, 8'h23};
        tbl[2] = '{1'b0, 4'd5,  8'h00, 2'b00, 8'h45, 8'h45};
        tbl[3] = '{1'b1, 4'd9,  8'hF1, 2'b10, 8'h00, 8'h45};
        tbl[4] = '{1'b0, 4'd9,  8'h00, 2'b00, 8'hF1, 8'hF1};
        tbl[5] = '{1'b1, 4'd12, 8'h90, 2'b11, 8'h00, 8'h00};
        tbl[6] = '{1'b0, 4'd12, 8'h00, 2'b00, 8'h90, 8'h90};

        // Reset, busy length, cleared contents
        tick(1'b1, 1'b0, 4'd0, 8'h00, 2'b00);
        chk("rst_busy", {7'b0, busy0}, 8'h01);
        chk("rst_dout", dout0, 8'h00);
        n = 0;
        while (busy0 && n < 100) begin
            idle(4'd0);
            n++;
        end
        chk("busy_len", 8'(n), 8'd16);
        for (int i = 0; i < DEPTH; i++) begin
            idle(4'(i));
            chk("clr_spo0", spo0_pre, 8'h00);
            chk("clr_spo1", spo1_pre, 8'hAA);
        end

        // Write modes, table-driven
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, tbl[i].w, tbl[i].ad, tbl[i].dd, tbl[i].md);
            chk("tbl_spo", spo0_pre, tbl[i].spo_exp);
            chk("tbl_dout", dout0, tbl[i].dout_exp);
            chk("tbl_dv", {7'b0, dv0}, 8'h01);
        end

        // Reset mid-sweep, write dropped while busy
        tick(1'b0, 1'b1, 4'd3, 8'h77, 2'b00);
        tick(1'b1, 1'b0, 4'd0, 8'h00, 2'b00);
        for (int k = 0; k < 5; k++) idle(4'd0);
        tick(1'b1, 1'b0, 4'd0, 8'h00, 2'b00);
        n = 0;
        while (busy0 && n < 100) begin
            if (n == 3) tick(1'b0, 1'b1, 4'd4, 8'h99, 2'b00);
            else idle(4'd0);
            n++;
        end
        chk("rerst_len", 8'(n), 8'd16);
        idle(4'd3);
        chk("rd3_spo", spo0_pre, 8'h00);
        chk("rd3_dout", dout0, 8'h00);
        idle(4'd4);
        chk("rd4_spo", spo0_pre, 8'h00);
        chk("rd4_dout", dout0, 8'h00);

        // Output-register latency and valid timing
        tick(1'b1, 1'b0, 4'd6, 8'h00, 2'b00);
        n = 0;
        while (busy0 && n < 100) begin
            chk("dv1_busy", {7'b0, dv1}, 8'h00);
            idle(4'd6);
            n++;
        end
        chk("oreg_len", 8'(n), 8'd16);
        chk("dv1_e0", {7'b0, dv1}, 8'h00);
        idle(4'd6);
        chk("dv0_e1", {7'b0, dv0}, 8'h01);
        chk("dv1_e1", {7'b0, dv1}, 8'h00);
        idle(4'd6);
        chk("dv1_e2", {7'b0, dv1}, 8'h01);
        chk("dout1_e2", dout1, 8'hAA);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            tick(($urandom_range(0, 59) == 0),
                 1'($urandom),
                 4'($urandom),
                 8'($urandom),
                 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
